// File: rtl/imem_responder.sv
//==============================================================================
// Module   : imem_responder
// Purpose  : Fixed-latency instruction memory responder with fetch stall/flush.
//            Optional one-entry last-fetch cache: IMEM_LAST_FETCH_CACHE_EN.
// Revision : 1.0
//==============================================================================
`default_nettype none

module imem_responder #(
    parameter int                DATA_W      = 32,
    parameter int                DEPTH       = 1024,
    parameter int                WAIT_CYCLES = 2,
    parameter logic [DATA_W-1:0] NOP_WORD    = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [19:0]       Daddress,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [19:0]       wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] instruction,
    output logic              valid,
    output logic              stall
);

    localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [20:0] DEPTH_LIM = 21'(DEPTH);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [19:0]         addr_q, addr_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   instr_q, instr_d;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   rd_word;
    logic                rd_in_range;
    logic                wr_in_range;

`ifdef IMEM_LAST_FETCH_CACHE_EN
    logic                cache_vld_q, cache_vld_d;
    logic [19:0]         cache_tag_q, cache_tag_d;
    logic [DATA_W-1:0]   cache_data_q, cache_data_d;
`endif

    assign rd_in_range = ({1'b0, addr_q} < DEPTH_LIM);
    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_LIM);
    assign rd_word     = rd_in_range ? mem[addr_q[AW-1:0]] : NOP_WORD;

    // Memory is not reset; the read above sees the pre-write word at a colliding edge.
    always_ff @(posedge clock) begin
        if (wr_en && wr_in_range) begin
            mem[wr_addr[AW-1:0]] <= wr_data;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        instr_d = instr_q;
`ifdef IMEM_LAST_FETCH_CACHE_EN
        cache_vld_d  = cache_vld_q;
        cache_tag_d  = cache_tag_q;
        cache_data_d = cache_data_q;
`endif
        case (state_q)
            IDLE: begin
                addr_d  = Daddress;
                cnt_d   = WAIT_INIT;
                state_d = WAIT;
`ifdef IMEM_LAST_FETCH_CACHE_EN
                if (cache_vld_q && (Daddress == cache_tag_q)) begin
                    state_d = DONE;
                    instr_d = cache_data_q;
                end
`endif
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    instr_d = rd_word;
                    state_d = DONE;
`ifdef IMEM_LAST_FETCH_CACHE_EN
                    cache_vld_d  = 1'b1;
                    cache_tag_d  = addr_q;
                    cache_data_d = rd_word;
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A jump abandons the access without touching any datapath register.
        if (flush) begin
            state_d = IDLE;
            addr_d  = addr_q;
            cnt_d   = cnt_q;
            instr_d = instr_q;
`ifdef IMEM_LAST_FETCH_CACHE_EN
            cache_vld_d  = cache_vld_q;
            cache_tag_d  = cache_tag_q;
            cache_data_d = cache_data_q;
`endif
        end

`ifdef IMEM_LAST_FETCH_CACHE_EN
        if (wr_en && (wr_addr == cache_tag_d)) begin
            cache_vld_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
        end
    end

`ifdef IMEM_LAST_FETCH_CACHE_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cache_vld_q  <= 1'b0;
            cache_tag_q  <= '0;
            cache_data_q <= '0;
        end else begin
            cache_vld_q  <= cache_vld_d;
            cache_tag_q  <= cache_tag_d;
            cache_data_q <= cache_data_d;
        end
    end
`endif

    assign instruction = instr_q;
    assign valid       = (state_q == DONE);
    assign stall       = (state_q != DONE);

endmodule

`default_nettype wire

// File: tb/tb_imem_responder.sv
//==============================================================================
// Module   : tb_imem_responder
// Purpose  : Self-checking bench for imem_responder (WAIT_CYCLES = 2).
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_imem_responder;

    localparam int DW    = 32;
    localparam int DEPTH = 1024;
    localparam int WC    = 2;

    logic          clock    = 1'b0;
    logic          reset    = 1'b1;
    logic [19:0]   Daddress = '0;
    logic          flush    = 1'b0;
    logic          wr_en    = 1'b0;
    logic [19:0]   wr_addr  = '0;
    logic [DW-1:0] wr_data  = '0;
    logic [DW-1:0] instruction;
    logic          valid;
    logic          stall;

    int checks = 0;
    int errors = 0;

    imem_responder #(
        .DATA_W      (DW),
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (WC),
        .NOP_WORD    ('0)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .Daddress    (Daddress),
        .flush       (flush),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .instruction (instruction),
        .valid       (valid),
        .stall       (stall)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Transaction-level model: edge numbers of the next sample and of delivery.
    logic [31:0] m_mem [DEPTH];
    int          cyc         = 0;
    int          next_sample = 1;
    int          done_e      = 0;
    bit          pend        = 1'b0;
    logic [19:0] p_addr      = '0;
    bit          exp_valid   = 1'b0;
    logic [31:0] exp_instr   = '0;
    bit          c_vld       = 1'b0;
    logic [19:0] c_tag       = '0;
    logic [31:0] c_data      = '0;

    function automatic logic [31:0] model_read(input logic [19:0] a);
        return (a < DEPTH) ? m_mem[a[9:0]] : 32'h0;
    endfunction

    always @(posedge reset) begin
        pend        = 1'b0;
        exp_valid   = 1'b0;
        exp_instr   = '0;
        c_vld       = 1'b0;
        next_sample = cyc + 1;
    end

    always @(posedge clock) begin
        cyc++;
        if (reset) begin
            pend        = 1'b0;
            exp_valid   = 1'b0;
            exp_instr   = '0;
            c_vld       = 1'b0;
            next_sample = cyc + 1;
        end else begin
            exp_valid = 1'b0;
            if (flush) begin
                pend        = 1'b0;
                next_sample = cyc + 1;
            end else if (cyc == next_sample) begin
                if (c_vld && Daddress == c_tag) begin
                    exp_valid   = 1'b1;
                    exp_instr   = c_data;
                    next_sample = cyc + 2;
                end else begin
                    pend        = 1'b1;
                    p_addr      = Daddress;
                    done_e      = cyc + WC;
                    next_sample = cyc + WC + 2;
                end
            end else if (pend && cyc == done_e) begin
                pend      = 1'b0;
                exp_valid = 1'b1;
                exp_instr = model_read(p_addr);
`ifdef IMEM_LAST_FETCH_CACHE_EN
                c_vld  = 1'b1;
                c_tag  = p_addr;
                c_data = exp_instr;
`endif
            end
        end
        if (wr_en) begin
            if (c_vld && wr_addr == c_tag) c_vld = 1'b0;
            if (wr_addr < DEPTH) m_mem[wr_addr[9:0]] = wr_data;
        end
    end

    always @(negedge clock) begin
        chk("valid", {31'b0, valid}, {31'b0, exp_valid});
        chk("stall", {31'b0, stall}, {31'b0, !exp_valid});
        chk("instruction", instruction, exp_instr);
    end

    task automatic wr(input logic [19:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clock);
        wr_en   = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!valid && n < 40);
        if (!valid) chk("valid_timeout", {31'b0, valid}, 32'd1);
    endtask

    initial begin
        int n;
        @(negedge clock);
        wr(20'd0,    32'h1111_0000);
        wr(20'd5,    32'h0000_5555);
        wr(20'd7,    32'h0000_7777);
        wr(20'd20,   32'h2020_2020);
        wr(20'd1023, 32'h003F_F3FF);
        chk("rst_stall", {31'b0, stall}, 32'd1);
        chk("rst_valid", {31'b0, valid}, 32'd0);
        chk("rst_instr", instruction, 32'h0);

        Daddress = 20'd0;
        reset    = 1'b0;
        wait_valid(n);
        chk("first_latency", n, 32'd3);
        chk("first_data", instruction, 32'h1111_0000);

        for (int i = 0; i < 4; i++) wr(20'(i), 32'hA0 + 32'(i));
        wait_valid(n);
        for (int k = 0; k < 4; k++) begin
            wait_valid(n);
            chk("seq_spacing", n, 32'd4);
            chk("seq_data", instruction, 32'hA0 + 32'(k));
            Daddress = (k == 3) ? 20'd5 : 20'(k + 1);
        end

        @(negedge clock);
        @(negedge clock);
        flush    = 1'b1;
        Daddress = 20'd20;
        @(negedge clock);
        flush    = 1'b0;
        wait_valid(n);
        chk("flush_latency", n, 32'd3);
        chk("flush_data", instruction, 32'h2020_2020);

        Daddress = 20'hFFFFF;
        wr(20'hFFFFF, 32'hDEAD_BEEF);
        wait_valid(n);
        chk("nop_data", instruction, 32'h0);
        Daddress = 20'd1023;
        wait_valid(n);
        chk("oob_write_ignored", instruction, 32'h003F_F3FF);

        Daddress = 20'd5;
        @(negedge clock);
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("midrst_valid", {31'b0, valid}, 32'd0);
        chk("midrst_stall", {31'b0, stall}, 32'd1);
        chk("midrst_instr", instruction, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        wait_valid(n);
        chk("postrst_latency", n, 32'd3);
        chk("postrst_data", instruction, 32'h0000_5555);

        Daddress = 20'd7;
        wait_valid(n);
        chk("fetch7_latency", n, 32'd4);
        chk("fetch7_data", instruction, 32'h0000_7777);
        wait_valid(n);
`ifdef IMEM_LAST_FETCH_CACHE_EN
        chk("repeat7_latency", n, 32'd2);
`else
        chk("repeat7_latency", n, 32'd4);
`endif
        chk("repeat7_data", instruction, 32'h0000_7777);
        wr(20'd7, 32'h0000_BEEF);
        wait_valid(n);
        chk("rewrite7_latency", n, 32'd3);
        chk("rewrite7_data", instruction, 32'h0000_BEEF);

        @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
